fnd_scan_rx: RTL and testbench

Receiver for the multiplexed six-digit 7-segment bus that the display path drives. It samples the active-low digit enables, segment lines and decimal point, and decodes each 7-segment pattern back to BCD. It assembles a full six-digit frame and presents hour/minute/second values plus a frame strobe. It sits beside the display outputs and provides board-level readback and self-check of the displayed time.

---
 rtl/fnd_scan_rx_if.sv | 34 +++
 rtl/fnd_scan_rx.sv | 207 ++++++++++++++++++++
 tb/tb_fnd_scan_rx.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fnd_scan_rx_if.sv
// Bus bundle for the six-digit 7-segment scan receiver.
//   i_seg_enb     : active-low digit enables, bit k low selects slot k
//   i_seg         : segments {a,b,c,d,e,f,g}, active-high
//   i_seg_dp      : decimal point of the selected slot
//   o_digits      : BCD per slot, slot k in [4k+3:4k]; 4'hF marks an undecodable slot
//   o_dp          : captured decimal point per slot
//   o_sec/min/hr  : binary pairs slot1:0, slot3:2, slot5:4 (6'h3F when invalid)
//   o_frame_valid : one-cycle strobe when the frame outputs update
//   o_frame_err   : last frame held an undecodable pattern
//   o_link_up     : captures arriving within the timeout window
// master drives the scan bus and reads results; slave is the receiver.
interface fnd_scan_rx_if;
  logic [5:0]  i_seg_enb;
  logic [6:0]  i_seg;
  logic        i_seg_dp;
  logic [23:0] o_digits;
  logic [5:0]  o_dp;
  logic [5:0]  o_sec;
  logic [5:0]  o_min;
  logic [5:0]  o_hr;
  logic        o_frame_valid;
  logic        o_frame_err;
  logic        o_link_up;

  modport master (
    output i_seg_enb, i_seg, i_seg_dp,
    input  o_digits, o_dp, o_sec, o_min, o_hr, o_frame_valid, o_frame_err, o_link_up
  );

  modport slave (
    input  i_seg_enb, i_seg, i_seg_dp,
    output o_digits, o_dp, o_sec, o_min, o_hr, o_frame_valid, o_frame_err, o_link_up
  );
endinterface

// File: rtl/fnd_scan_rx.sv
// Readback receiver for the multiplexed six-digit 7-segment display bus.
// Synchronizes the scan lines, waits for each enable pattern to settle, decodes
// the segments of the selected slot to BCD and assembles a six-slot frame.
// A completed frame updates digits, decimal points, sec/min/hr and pulses
// o_frame_valid. A link watchdog drops o_link_up when captures stop.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : fnd_scan_rx_if.slave (scan inputs and frame outputs)
module fnd_scan_rx #(
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input logic          clk,
  input logic          rst_n,
  fnd_scan_rx_if.slave bus
);

  localparam logic [7:0]  SettleMax  = 8'(SETTLE_CYC);
  localparam logic [7:0]  SettleHit  = 8'(SETTLE_CYC - 1);
  localparam logic [31:0] TimeoutMax = 32'(TIMEOUT_CYC);
  localparam logic [31:0] TimeoutHit = 32'(TIMEOUT_CYC - 1);

  // 7-segment pattern to BCD; anything unknown maps to 4'hF.
  function automatic logic [3:0] seg_decode(input logic [6:0] p);
    logic [3:0] d;
    case (p)
      7'b1111110: d = 4'd0;
      7'b0110000: d = 4'd1;
      7'b1101101: d = 4'd2;
      7'b1111001: d = 4'd3;
      7'b0110011: d = 4'd4;
      7'b1011011: d = 4'd5;
      7'b1011111: d = 4'd6;
      7'b1110000: d = 4'd7;
      7'b1111111: d = 4'd8;
      7'b1110011: d = 4'd9;
      default:    d = 4'hF;
    endcase
    return d;
  endfunction

  // tens*10 + ones; undecodable digits or results above 63 saturate to 6'h3F.
  function automatic logic [5:0] to_bin(input logic [3:0] tens, input logic [3:0] ones);
    logic [6:0] v;
    v = 7'(tens) * 7'd10 + 7'(ones);
    if (tens == 4'hF || ones == 4'hF || v > 7'd63) begin
      return 6'h3F;
    end
    return v[5:0];
  endfunction

  // Two-flop synchronizers
  logic [5:0]  enb_meta_q, enb_s_q, enb_prev_q;
  logic [6:0]  seg_meta_q, seg_s_q;
  logic        dp_meta_q, dp_s_q;

  logic [7:0]  settle_q, settle_d;
  logic [31:0] idle_q, idle_d;
  logic [5:0]  mask_q, mask_d;
  logic        err_q, err_d;
  logic [23:0] shadow_q, shadow_d;
  logic [5:0]  sdp_q, sdp_d;

  logic [23:0] digits_q, digits_d;
  logic [5:0]  dp_q, dp_d;
  logic [5:0]  sec_q, sec_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  hr_q, hr_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        link_q, link_d;

  logic        stable, onehot_low, capture, timeout_hit, frame_done;
  logic [2:0]  slot;
  logic [3:0]  cap_nib;

  always_comb begin
    stable      = (enb_s_q == enb_prev_q);
    onehot_low  = $onehot(~enb_s_q);
    // Fires exactly once per dwell: the cycle the counter steps onto SETTLE_CYC.
    capture     = stable && onehot_low && (settle_q == SettleHit);
    timeout_hit = (idle_q == TimeoutHit);
    frame_done  = (mask_q == 6'h3F);
    cap_nib     = seg_decode(seg_s_q);

    slot = 3'd0;
    for (int k = 0; k < 6; k++) begin
      if (!enb_s_q[k]) slot = 3'(k);
    end

    if (!stable) begin
      settle_d = 8'd0;
    end else if (settle_q != SettleMax) begin
      settle_d = settle_q + 8'd1;
    end else begin
      settle_d = settle_q;
    end

    if (capture) begin
      idle_d = 32'd0;
    end else if (idle_q != TimeoutMax) begin
      idle_d = idle_q + 32'd1;
    end else begin
      idle_d = idle_q;
    end

    link_d = link_q;
    if (capture) begin
      link_d = 1'b1;
    end else if (timeout_hit) begin
      link_d = 1'b0;
    end

    mask_d   = mask_q;
    err_d    = err_q;
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    // A completed frame or a dead link restarts assembly; a capture in the same
    // cycle still lands in the fresh mask.
    if (frame_done || (timeout_hit && !capture)) begin
      mask_d = 6'd0;
      err_d  = 1'b0;
    end
    if (capture) begin
      mask_d[slot]               = 1'b1;
      shadow_d[{slot, 2'b00} +: 4] = cap_nib;
      sdp_d[slot]                = dp_s_q;
      if (cap_nib == 4'hF) err_d = 1'b1;
    end

    digits_d = digits_q;
    dp_d     = dp_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    ferr_d   = ferr_q;
    valid_d  = frame_done;
    if (frame_done) begin
      digits_d = shadow_q;
      dp_d     = sdp_q;
      sec_d    = to_bin(shadow_q[7:4], shadow_q[3:0]);
      min_d    = to_bin(shadow_q[15:12], shadow_q[11:8]);
      hr_d     = to_bin(shadow_q[23:20], shadow_q[19:16]);
      ferr_d   = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Enables idle as all-ones (blank) so reset never looks like a selection.
      enb_meta_q <= 6'h3F;
      enb_s_q    <= 6'h3F;
      enb_prev_q <= 6'h3F;
      seg_meta_q <= 7'd0;
      seg_s_q    <= 7'd0;
      dp_meta_q  <= 1'b0;
      dp_s_q     <= 1'b0;
      settle_q   <= 8'd0;
      idle_q     <= 32'd0;
      mask_q     <= 6'd0;
      err_q      <= 1'b0;
      shadow_q   <= 24'd0;
      sdp_q      <= 6'd0;
      digits_q   <= 24'd0;
      dp_q       <= 6'd0;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hr_q       <= 6'd0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      link_q     <= 1'b0;
    end else begin
      enb_meta_q <= bus.i_seg_enb;
      enb_s_q    <= enb_meta_q;
      enb_prev_q <= enb_s_q;
      seg_meta_q <= bus.i_seg;
      seg_s_q    <= seg_meta_q;
      dp_meta_q  <= bus.i_seg_dp;
      dp_s_q     <= dp_meta_q;
      settle_q   <= settle_d;
      idle_q     <= idle_d;
      mask_q     <= mask_d;
      err_q      <= err_d;
      shadow_q   <= shadow_d;
      sdp_q      <= sdp_d;
      digits_q   <= digits_d;
      dp_q       <= dp_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      link_q     <= link_d;
    end
  end

  assign bus.o_digits      = digits_q;
  assign bus.o_dp          = dp_q;
  assign bus.o_sec         = sec_q;
  assign bus.o_min         = min_q;
  assign bus.o_hr          = hr_q;
  assign bus.o_frame_valid = valid_q;
  assign bus.o_frame_err   = ferr_q;
  assign bus.o_link_up     = link_q;

endmodule

// File: tb/tb_fnd_scan_rx.sv
// Bench for fnd_scan_rx: directed and randomized scan traffic, expected frames
// queued by a reference model, checked by an independent frame monitor.
module tb_fnd_scan_rx;
  localparam int unsigned SETTLE  = 8;
  localparam int unsigned TIMEOUT = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  fnd_scan_rx_if bus ();

  fnd_scan_rx #(
    .SETTLE_CYC (SETTLE),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [5:0]  hr;
    logic        err;
  } frame_t;

  frame_t exp_q[$];
  int tests = 0;
  int fails = 0;

  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

  // Reference state: what has been captured in the current frame
  logic [3:0] m_dig [6];
  logic       m_dp  [6];
  bit         m_have[6];
  bit         m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) begin
      if (p == seg_tab[i]) return 4'(i);
    end
    return 4'hF;
  endfunction

  function automatic logic [5:0] ref_pair(input logic [3:0] t, input logic [3:0] o);
    int v;
    if (t == 4'hF || o == 4'hF) return 6'd63;
    v = int'(t) * 10 + int'(o);
    if (v > 63) return 6'd63;
    return 6'(v);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 6; k++) m_have[k] = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_capture(input int k, input logic [6:0] p, input logic dp);
    frame_t f;
    bit full;
    m_dig[k]  = ref_decode(p);
    m_dp[k]   = dp;
    m_have[k] = 1'b1;
    if (m_dig[k] == 4'hF) m_err = 1'b1;
    full = 1'b1;
    for (int i = 0; i < 6; i++) full &= m_have[i];
    if (full) begin
      for (int i = 0; i < 6; i++) begin
        f.digits[4*i +: 4] = m_dig[i];
        f.dp[i]            = m_dp[i];
      end
      f.sec = ref_pair(m_dig[1], m_dig[0]);
      f.min = ref_pair(m_dig[3], m_dig[2]);
      f.hr  = ref_pair(m_dig[5], m_dig[4]);
      f.err = m_err;
      exp_q.push_back(f);
      model_clear();
    end
  endtask

  // Called at a negedge; holds the values for 'cycles' clocks.
  task automatic drive(input logic [5:0] enb, input logic [6:0] seg, input logic dp,
                       input int cycles);
    bus.i_seg_enb = enb;
    bus.i_seg     = seg;
    bus.i_seg_dp  = dp;
    repeat (cycles) @(negedge clk);
  endtask

  function automatic logic [6:0] rand_pat();
    if ($urandom_range(0, 7) == 0) return 7'($urandom());
    return seg_tab[$urandom_range(0, 9)];
  endfunction

  task automatic scan_slot(input int k, input logic [6:0] p, input logic dp);
    int gap;
    gap = $urandom_range(0, 3);
    if (gap > 0) drive(6'h3F, 7'd0, 1'b0, gap);
    model_capture(k, p, dp);
    drive(~(6'b1 << k), p, dp, $urandom_range(SETTLE + 6, SETTLE + 30));
  endtask

  // Traffic that must never capture
  task automatic noise();
    int a, b;
    logic [5:0] e;
    case ($urandom_range(0, 3))
      1: begin
        drive(6'h3F, 7'd0, 1'b0, 1);
        drive(6'h3E, rand_pat(), 1'b1, 3);
        drive(6'h3F, 7'd0, 1'b0, 1);
      end
      2: begin
        a = $urandom_range(0, 5);
        b = (a + $urandom_range(1, 5)) % 6;
        e = 6'h3F;
        e[a] = 1'b0;
        e[b] = 1'b0;
        drive(e, rand_pat(), 1'b0, SETTLE + 12);
      end
      3: drive(6'h3F, rand_pat(), 1'b0, 40);
      default: ;
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " digits"}, bus.o_digits, 0);
    check({tag, " dp"}, bus.o_dp, 0);
    check({tag, " sec"}, bus.o_sec, 0);
    check({tag, " min"}, bus.o_min, 0);
    check({tag, " hr"}, bus.o_hr, 0);
    check({tag, " valid"}, bus.o_frame_valid, 0);
    check({tag, " err"}, bus.o_frame_err, 0);
    check({tag, " link"}, bus.o_link_up, 0);
  endtask

  // Monitor: every frame strobe must match the oldest expected frame
  initial begin
    frame_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.o_frame_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected frame: got digits %0h expected no frame", bus.o_digits);
        end else begin
          e = exp_q.pop_front();
          check("frame digits", bus.o_digits, e.digits);
          check("frame dp", bus.o_dp, e.dp);
          check("frame sec", bus.o_sec, e.sec);
          check("frame min", bus.o_min, e.min);
          check("frame hr", bus.o_hr, e.hr);
          check("frame err", bus.o_frame_err, e.err);
        end
      end
    end
  end

  initial begin
    logic [6:0] p;
    int n;
    model_clear();
    bus.i_seg_enb = 6'h3F;
    bus.i_seg     = 7'd0;
    bus.i_seg_dp  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Clean frame 12:34:57
    scan_slot(0, seg_tab[7], 1'b0);
    scan_slot(1, seg_tab[5], 1'b0);
    scan_slot(2, seg_tab[4], 1'b0);
    scan_slot(3, seg_tab[3], 1'b0);
    scan_slot(4, seg_tab[2], 1'b0);
    scan_slot(5, seg_tab[1], 1'b1);
    drive(6'h3F, 7'd0, 1'b0, 20);
    check("clean digits", bus.o_digits, 24'h123457);
    check("clean sec", bus.o_sec, 57);
    check("clean min", bus.o_min, 34);
    check("clean hr", bus.o_hr, 12);
    check("clean err", bus.o_frame_err, 0);
    check("clean link", bus.o_link_up, 1);

    // Same frame with an undecodable slot2
    scan_slot(0, seg_tab[7], 1'b0);
    scan_slot(1, seg_tab[5], 1'b0);
    scan_slot(2, 7'b0000001, 1'b0);
    scan_slot(3, seg_tab[3], 1'b0);
    scan_slot(4, seg_tab[2], 1'b0);
    scan_slot(5, seg_tab[1], 1'b0);
    drive(6'h3F, 7'd0, 1'b0, 20);
    check("bad slot2", bus.o_digits[11:8], 4'hF);
    check("bad min", bus.o_min, 6'h3F);
    check("bad err", bus.o_frame_err, 1);
    for (int k = 0; k < 6; k++) scan_slot(k, seg_tab[k + 2], 1'b0);
    drive(6'h3F, 7'd0, 1'b0, 20);
    check("err cleared", bus.o_frame_err, 0);

    // Latency: raw edge -> first sync edge, +2+SETTLE to capture, +1 to strobe
    for (int k = 0; k < 5; k++) scan_slot(k, rand_pat(), 1'($urandom()));
    drive(6'h3F, 7'd0, 1'b0, 2);
    model_capture(5, seg_tab[3], 1'b0);
    bus.i_seg_enb = 6'h1F;
    bus.i_seg     = seg_tab[3];
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.o_frame_valid === 1'b1) break;
    end
    check("latency", n, 1 + (2 + SETTLE) + 1);
    @(negedge clk);
    drive(6'h3F, 7'd0, 1'b0, 10);

    // Glitch, two-low and blank traffic mid-frame must not disturb slot0
    scan_slot(0, seg_tab[1], 1'b0);
    scan_slot(1, rand_pat(), 1'b0);
    scan_slot(2, rand_pat(), 1'b0);
    drive(6'h3F, 7'd0, 1'b0, 1);
    drive(6'h3E, seg_tab[9], 1'b1, 3);
    drive(6'h3F, 7'd0, 1'b0, 1);
    drive(6'h3C, seg_tab[9], 1'b1, SETTLE + 20);
    drive(6'h3F, seg_tab[9], 1'b0, SETTLE + 20);
    scan_slot(3, rand_pat(), 1'b0);
    scan_slot(4, rand_pat(), 1'b0);
    scan_slot(5, rand_pat(), 1'b0);

    // Timeout after three slots; resumed scan needs a full frame
    for (int k = 0; k < 3; k++) scan_slot(k, rand_pat(), 1'($urandom()));
    drive(6'h3F, 7'd0, 1'b0, TIMEOUT + 20);
    model_clear();
    check("timeout link", bus.o_link_up, 0);
    scan_slot(3, rand_pat(), 1'b0);
    check("resume link", bus.o_link_up, 1);
    scan_slot(4, rand_pat(), 1'b0);
    scan_slot(5, rand_pat(), 1'b0);
    for (int k = 0; k < 3; k++) scan_slot(k, rand_pat(), 1'($urandom()));

    // Reset after four captures discards the partial frame
    for (int k = 0; k < 4; k++) scan_slot(k, rand_pat(), 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_clear();
    drive(6'h3F, 7'd0, 1'b0, 3);
    rst_n = 1'b1;
    scan_slot(4, rand_pat(), 1'b0);
    scan_slot(5, rand_pat(), 1'b0);
    for (int k = 0; k < 4; k++) scan_slot(k, rand_pat(), 1'($urandom()));

    // Randomized frames with interleaved non-capturing traffic
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < 6; k++) begin
        noise();
        p = rand_pat();
        scan_slot(k, p, 1'($urandom()));
      end
    end

    drive(6'h3F, 7'd0, 1'b0, 30);
    check("pending frames", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
